// File: rtl/regfile_renamed_pkg.sv
// ---------------------------------------------------------------------------
// regfile_renamed_pkg
//   Shared defaults and types for the renamed architectural register file.
//   Holds the default widths used by regfile_renamed and regfile_read_port.
//   reg_entry_t bundles the state kept for one architectural register at the
//   default widths: committed value, busy bit and producer ROB tag.
// ---------------------------------------------------------------------------
package regfile_renamed_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int NUM_REGS_DEF     = 32;
  localparam int REG_ID_W_DEF     = 5;
  localparam int TAG_W_DEF        = 4;
  localparam int NUM_RD_PORTS_DEF = 2;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  val;
    logic                 busy;
    logic [TAG_W_DEF-1:0] tag;
  } reg_entry_t;

endpackage

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//   One combinational read channel of the renamed register file.
//   Masks index 0 to value 0 / not busy / tag 0. When the macro
//   REGFILE_COMMIT_BYPASS_EN is defined, a commit that would retire the
//   register's current producer is forwarded into the read in the same cycle.
//
//   Ports:
//     reg_id        read index
//     state_val     registered value of reg_id
//     state_busy    registered busy bit of reg_id
//     state_tag     registered producer tag of reg_id
//     commit_*      commit bus (present only with REGFILE_COMMIT_BYPASS_EN)
//     rd_val        value returned to the reader
//     rd_busy       register awaits an in-flight producer
//     rd_tag        producer ROB tag, meaningful only when rd_busy
// ---------------------------------------------------------------------------
module regfile_read_port
  import regfile_renamed_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic [REG_ID_W-1:0] reg_id,
  input  logic [XLEN-1:0]     state_val,
  input  logic                state_busy,
  input  logic [TAG_W-1:0]    state_tag,
`ifdef REGFILE_COMMIT_BYPASS_EN
  input  logic                commit_valid,
  input  logic [REG_ID_W-1:0] commit_rd,
  input  logic [TAG_W-1:0]    commit_tag,
  input  logic [XLEN-1:0]     commit_val,
`endif
  output logic [XLEN-1:0]     rd_val,
  output logic                rd_busy,
  output logic [TAG_W-1:0]    rd_tag
);

  always_comb begin
    rd_val  = '0;
    rd_busy = 1'b0;
    rd_tag  = '0;
    if (reg_id != '0) begin
      rd_val  = state_val;
      rd_busy = state_busy;
      rd_tag  = state_tag;
`ifdef REGFILE_COMMIT_BYPASS_EN
      // Forward only when the commit retires the producer the register is
      // waiting on; a stale-tag commit must not mask a younger producer.
      if (commit_valid && (commit_rd == reg_id) && state_busy &&
          (state_tag == commit_tag)) begin
        rd_val  = commit_val;
        rd_busy = 1'b0;
        rd_tag  = '0;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_renamed.sv
// ---------------------------------------------------------------------------
// regfile_renamed
//   Architectural register file with rename state for the out-of-order core.
//   Each register holds a committed value, a busy bit and the ROB tag of its
//   youngest in-flight producer. One rename (issue) write and one commit write
//   per cycle; flush clears all rename state. Register 0 is hardwired zero.
//   Optional macro REGFILE_COMMIT_BYPASS_EN enables same-cycle commit
//   forwarding on every read channel.
//
//   Ports:
//     clk_in         system clock, rising edge
//     rst_in         synchronous active-high reset, clears all state
//     rdy_in         global ready; low freezes all state
//     flush_pipline  clears busy bits and tags, drops same-cycle issue
//     rd_reg_id      read indices, channel k in slice k
//     rd_val/rd_busy/rd_tag  per-channel read results (combinational)
//     issue_*        rename write: mark issue_rd busy with issue_tag
//     commit_*       commit write: value update, conditional busy clear
// ---------------------------------------------------------------------------
module regfile_renamed
  import regfile_renamed_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int REG_ID_W     = REG_ID_W_DEF,
  parameter int TAG_W        = TAG_W_DEF,
  parameter int NUM_RD_PORTS = NUM_RD_PORTS_DEF
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             flush_pipline,
  input  logic [NUM_RD_PORTS*REG_ID_W-1:0] rd_reg_id,
  output logic [NUM_RD_PORTS*XLEN-1:0]     rd_val,
  output logic [NUM_RD_PORTS-1:0]          rd_busy,
  output logic [NUM_RD_PORTS*TAG_W-1:0]    rd_tag,
  input  logic                             issue_valid,
  input  logic [REG_ID_W-1:0]              issue_rd,
  input  logic [TAG_W-1:0]                 issue_tag,
  input  logic                             commit_valid,
  input  logic [REG_ID_W-1:0]              commit_rd,
  input  logic [TAG_W-1:0]                 commit_tag,
  input  logic [XLEN-1:0]                  commit_val
);

  logic [XLEN-1:0]     reg_val  [NUM_REGS];
  logic [NUM_REGS-1:0] reg_busy;
  logic [TAG_W-1:0]    reg_tag  [NUM_REGS];

  logic commit_en;
  logic commit_retires;
  logic issue_en;

  assign commit_en      = commit_valid && (commit_rd != '0);
  // The busy bit only drops if the committing entry is still the register's
  // current producer; otherwise a younger rename owns it.
  assign commit_retires = commit_en && reg_busy[commit_rd] &&
                          (reg_tag[commit_rd] == commit_tag);
  assign issue_en       = issue_valid && (issue_rd != '0) && !flush_pipline;

  // State update: issue is applied after commit so it wins on a same-register
  // collision; flush overrides both rename updates but not the value write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_val[i] <= '0;
        reg_tag[i] <= '0;
      end
      reg_busy <= '0;
    end else if (rdy_in) begin
      if (commit_en) begin
        reg_val[commit_rd] <= commit_val;
      end
      if (flush_pipline) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          reg_tag[i] <= '0;
        end
        reg_busy <= '0;
      end else begin
        if (commit_retires) begin
          reg_busy[commit_rd] <= 1'b0;
        end
        if (issue_en) begin
          reg_busy[issue_rd] <= 1'b1;
          reg_tag[issue_rd]  <= issue_tag;
        end
      end
    end
  end

  // Read channels
  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [REG_ID_W-1:0] idx;
    assign idx = rd_reg_id[k*REG_ID_W +: REG_ID_W];

    regfile_read_port #(
      .XLEN     (XLEN),
      .REG_ID_W (REG_ID_W),
      .TAG_W    (TAG_W)
    ) u_port (
      .reg_id       (idx),
      .state_val    (reg_val[idx]),
      .state_busy   (reg_busy[idx]),
      .state_tag    (reg_tag[idx]),
`ifdef REGFILE_COMMIT_BYPASS_EN
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_tag),
      .commit_val   (commit_val),
`endif
      .rd_val       (rd_val[k*XLEN +: XLEN]),
      .rd_busy      (rd_busy[k]),
      .rd_tag       (rd_tag[k*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_regfile_renamed.sv
// ---------------------------------------------------------------------------
// tb_regfile_renamed
//   Directed bench for regfile_renamed at default parameters. Each read
//   channel is observed as {val, busy, tag}; expected bundles are written
//   out by hand per scenario. Define REGFILE_COMMIT_BYPASS_EN for both the
//   bench and the RTL to exercise the forwarding build.
// ---------------------------------------------------------------------------
module tb_regfile_renamed;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_pipline;
  logic [9:0]  rd_reg_id;
  logic [63:0] rd_val;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_val;

  int total;
  int bad;

  logic [36:0] p0;
  logic [36:0] p1;
  assign p0 = {rd_val[31:0],  rd_busy[0], rd_tag[3:0]};
  assign p1 = {rd_val[63:32], rd_busy[1], rd_tag[7:4]};

  regfile_renamed dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_pipline (flush_pipline),
    .rd_reg_id     (rd_reg_id),
    .rd_val        (rd_val),
    .rd_busy       (rd_busy),
    .rd_tag        (rd_tag),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_tag     (issue_tag),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_tag    (commit_tag),
    .commit_val    (commit_val)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic idle();
    rdy_in        = 1'b1;
    flush_pipline = 1'b0;
    issue_valid   = 1'b0;
    issue_rd      = 5'd0;
    issue_tag     = 4'd0;
    commit_valid  = 1'b0;
    commit_rd     = 5'd0;
    commit_tag    = 4'd0;
    commit_val    = 32'd0;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_reg_id = {b, a};
    #1;
  endtask

  task automatic test_reset();
    // reset must win over rdy_in low and active write requests
    rst_in = 1'b1; rdy_in = 1'b0; flush_pipline = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd9;
    commit_valid = 1'b1; commit_rd = 5'd6; commit_tag = 4'd1; commit_val = 32'hFFFF_FFFF;
    cyc(); cyc();
    rst_in = 1'b0;
    idle();
    for (int i = 1; i < 32; i++) begin
      rd(5'(i), 5'(32 - i));
      total++;
      if (p0 !== 37'd0) begin
        bad++; $display("FAIL reset_p0 x%0d got=%h exp=%h", i, p0, 37'd0);
      end
      total++;
      if (p1 !== 37'd0) begin
        bad++; $display("FAIL reset_p1 x%0d got=%h exp=%h", 32 - i, p1, 37'd0);
      end
    end
  endtask

  task automatic test_issue_commit();
    cyc(); idle();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    rd(5'd5, 5'd0);
    total++;
    if (p0 !== {32'h0, 1'b0, 4'd0}) begin
      bad++; $display("FAIL issue_not_early got=%h exp=%h", p0, {32'h0, 1'b0, 4'd0});
    end
    cyc(); idle();
    rd(5'd5, 5'd0);
    total++;
    if (p0 !== {32'h0, 1'b1, 4'd3}) begin
      bad++; $display("FAIL issue_x5 got=%h exp=%h", p0, {32'h0, 1'b1, 4'd3});
    end
    total++;
    if (p1 !== 37'd0) begin
      bad++; $display("FAIL issue_x0_other got=%h exp=%h", p1, 37'd0);
    end
    commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_val = 32'hDEAD_BEEF;
    rd(5'd5, 5'd5);
    total++;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (p0 !== {32'hDEAD_BEEF, 1'b0, 4'd0}) begin
      bad++; $display("FAIL bypass_x5 got=%h exp=%h", p0, {32'hDEAD_BEEF, 1'b0, 4'd0});
    end
`else
    if (p0 !== {32'h0, 1'b1, 4'd3}) begin
      bad++; $display("FAIL nobypass_x5 got=%h exp=%h", p0, {32'h0, 1'b1, 4'd3});
    end
`endif
    cyc(); idle();
    rd(5'd5, 5'd0);
    total++;
    if (p0[36:4] !== {32'hDEAD_BEEF, 1'b0}) begin
      bad++; $display("FAIL commit_x5 got=%h exp=%h", p0[36:4], {32'hDEAD_BEEF, 1'b0});
    end
  endtask

  task automatic test_younger_producer();
    cyc(); idle();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_tag = 4'd2;
    cyc();
    issue_tag = 4'd6;
    cyc(); idle();
    commit_valid = 1'b1; commit_rd = 5'd7; commit_tag = 4'd2; commit_val = 32'h11;
    rd(5'd7, 5'd0);
    // stale tag: no forwarding even in the bypass build
    total++;
    if (p0 !== {32'h0, 1'b1, 4'd6}) begin
      bad++; $display("FAIL stale_commit_pre got=%h exp=%h", p0, {32'h0, 1'b1, 4'd6});
    end
    cyc(); idle();
    rd(5'd7, 5'd0);
    total++;
    if (p0 !== {32'h11, 1'b1, 4'd6}) begin
      bad++; $display("FAIL stale_commit_x7 got=%h exp=%h", p0, {32'h11, 1'b1, 4'd6});
    end
  endtask

  task automatic test_same_cycle();
    cyc(); idle();
    issue_valid = 1'b1; issue_rd = 5'd9; issue_tag = 4'd1;
    cyc(); idle();
    issue_valid = 1'b1; issue_rd = 5'd9; issue_tag = 4'd4;
    commit_valid = 1'b1; commit_rd = 5'd9; commit_tag = 4'd1; commit_val = 32'h22;
    rd(5'd9, 5'd9);
    total++;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (p1 !== {32'h22, 1'b0, 4'd0}) begin
      bad++; $display("FAIL bypass_x9 got=%h exp=%h", p1, {32'h22, 1'b0, 4'd0});
    end
`else
    if (p1 !== {32'h0, 1'b1, 4'd1}) begin
      bad++; $display("FAIL nobypass_x9 got=%h exp=%h", p1, {32'h0, 1'b1, 4'd1});
    end
`endif
    cyc(); idle();
    rd(5'd9, 5'd0);
    total++;
    if (p0 !== {32'h22, 1'b1, 4'd4}) begin
      bad++; $display("FAIL issue_commit_x9 got=%h exp=%h", p0, {32'h22, 1'b1, 4'd4});
    end
  endtask

  task automatic test_x0();
    cyc(); idle();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd5;
    commit_valid = 1'b1; commit_rd = 5'd0; commit_tag = 4'd0; commit_val = 32'hFFFF_FFFF;
    rd(5'd0, 5'd0);
    total++;
    if (p0 !== 37'd0) begin
      bad++; $display("FAIL x0_pre got=%h exp=%h", p0, 37'd0);
    end
    cyc(); idle();
    rd(5'd0, 5'd0);
    total++;
    if (p0 !== 37'd0) begin
      bad++; $display("FAIL x0_p0 got=%h exp=%h", p0, 37'd0);
    end
    total++;
    if (p1 !== 37'd0) begin
      bad++; $display("FAIL x0_p1 got=%h exp=%h", p1, 37'd0);
    end
  endtask

  task automatic test_stall();
    cyc(); idle();
    rdy_in = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd10; issue_tag = 4'd5;
    commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_val = 32'h99;
    rd(5'd10, 5'd7);
    total++;
    if (p1 !== {32'h11, 1'b1, 4'd6}) begin
      bad++; $display("FAIL stall_read_x7 got=%h exp=%h", p1, {32'h11, 1'b1, 4'd6});
    end
    cyc(); cyc(); idle();
    rd(5'd10, 5'd5);
    total++;
    if (p0 !== 37'd0) begin
      bad++; $display("FAIL stall_issue_x10 got=%h exp=%h", p0, 37'd0);
    end
    total++;
    if (p1[36:4] !== {32'hDEAD_BEEF, 1'b0}) begin
      bad++; $display("FAIL stall_commit_x5 got=%h exp=%h", p1[36:4], {32'hDEAD_BEEF, 1'b0});
    end
  endtask

  task automatic test_flush();
    cyc(); idle();
    issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 4'd1;
    cyc();
    issue_rd = 5'd4; issue_tag = 4'd2;
    cyc(); idle();
    rd(5'd3, 5'd4);
    total++;
    if (p0 !== {32'h0, 1'b1, 4'd1}) begin
      bad++; $display("FAIL preflush_x3 got=%h exp=%h", p0, {32'h0, 1'b1, 4'd1});
    end
    total++;
    if (p1 !== {32'h0, 1'b1, 4'd2}) begin
      bad++; $display("FAIL preflush_x4 got=%h exp=%h", p1, {32'h0, 1'b1, 4'd2});
    end
    flush_pipline = 1'b1;
    commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 4'd1; commit_val = 32'h33;
    issue_valid = 1'b1; issue_rd = 5'd8; issue_tag = 4'd7;
    cyc(); idle();
    rd(5'd3, 5'd4);
    total++;
    if (p0 !== {32'h33, 1'b0, 4'd0}) begin
      bad++; $display("FAIL flush_x3 got=%h exp=%h", p0, {32'h33, 1'b0, 4'd0});
    end
    total++;
    if (p1 !== 37'd0) begin
      bad++; $display("FAIL flush_x4 got=%h exp=%h", p1, 37'd0);
    end
    rd(5'd8, 5'd7);
    total++;
    if (p0 !== 37'd0) begin
      bad++; $display("FAIL flush_issue_x8 got=%h exp=%h", p0, 37'd0);
    end
    total++;
    if (p1 !== {32'h11, 1'b0, 4'd0}) begin
      bad++; $display("FAIL flush_x7 got=%h exp=%h", p1, {32'h11, 1'b0, 4'd0});
    end
    rd(5'd9, 5'd0);
    total++;
    if (p0 !== {32'h22, 1'b0, 4'd0}) begin
      bad++; $display("FAIL flush_x9 got=%h exp=%h", p0, {32'h22, 1'b0, 4'd0});
    end
  endtask

  task automatic test_back_to_back();
    cyc(); idle();
    issue_valid = 1'b1; issue_rd = 5'd12; issue_tag = 4'd3;
    cyc();
    issue_rd = 5'd13; issue_tag = 4'd4;
    rd(5'd12, 5'd13);
    total++;
    if (p0 !== {32'h0, 1'b1, 4'd3}) begin
      bad++; $display("FAIL b2b_x12 got=%h exp=%h", p0, {32'h0, 1'b1, 4'd3});
    end
    total++;
    if (p1 !== 37'd0) begin
      bad++; $display("FAIL b2b_x13_pre got=%h exp=%h", p1, 37'd0);
    end
    cyc(); idle();
    commit_valid = 1'b1; commit_rd = 5'd12; commit_tag = 4'd3; commit_val = 32'hA5;
    cyc();
    commit_rd = 5'd13; commit_tag = 4'd4; commit_val = 32'h5A;
    rd(5'd12, 5'd0);
    total++;
    if (p0[36:4] !== {32'hA5, 1'b0}) begin
      bad++; $display("FAIL b2b_commit_x12 got=%h exp=%h", p0[36:4], {32'hA5, 1'b0});
    end
    cyc(); idle();
    rd(5'd12, 5'd13);
    total++;
    if (p1[36:4] !== {32'h5A, 1'b0}) begin
      bad++; $display("FAIL b2b_commit_x13 got=%h exp=%h", p1[36:4], {32'h5A, 1'b0});
    end
    total++;
    if (p0[36:4] !== {32'hA5, 1'b0}) begin
      bad++; $display("FAIL b2b_hold_x12 got=%h exp=%h", p0[36:4], {32'hA5, 1'b0});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rd_reg_id = 10'd0;
    test_reset();
    test_issue_commit();
    test_younger_producer();
    test_same_cycle();
    test_x0();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
